// File: rtl/lb_ctrl_pkg.sv
// Shared types and constants for the line-buffer stream controller.
// Holds the FSM state encoding, default counter width and latency bounds.
package lb_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL   = 2'd1,
      STEADY = 2'd2,
      DRAIN  = 2'd3
   } lb_state_t;

   localparam int CW_DEF       = 16;
   localparam int READ_LAT_MIN = 1;
   localparam int READ_LAT_MAX = 4;

endpackage

// File: rtl/lb_lat_pipe.sv
// Valid shift register matching the core read latency.
// Ports: clk, reset, en (advance), clr (sync clear), din, dout, empty.
module lb_lat_pipe #(
   parameter int LAT = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   input  logic din,
   output logic dout,
   output logic empty
);

   logic [LAT-1:0] sr;

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         sr <= '0;
      end else if (en) begin
         sr[0] <= din;
         for (int i = 1; i < LAT; i++) begin
            sr[i] <= sr[i-1];
         end
      end
   end

   assign dout  = sr[LAT-1];
   assign empty = ~|sr;

endmodule

// File: rtl/lb_stream_ctrl.sv
// Line-buffer sequencer: fill to depth, rate-matched steady state, drain.
// Ports: stream in (in_valid/in_last/in_ready), core strobes
// (mem_wen/mem_ren), out_valid, occupancy, busy/done/cfg_err status.
module lb_stream_ctrl
   import lb_ctrl_pkg::*;
#(
   parameter int DW       = 16,
   parameter int CW       = CW_DEF,
   parameter int READ_LAT = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clk_en,
   input  logic          flush,
   input  logic          cfg_start,
   input  logic [CW-1:0] cfg_depth,
   input  logic          in_valid,
   input  logic          in_last,
   output logic          in_ready,
   output logic          mem_wen,
   output logic          mem_ren,
   output logic          out_valid,
   output logic [CW-1:0] occupancy,
   output logic          busy,
   output logic          done,
   output logic          cfg_err
);

   if (DW < 1 || READ_LAT < READ_LAT_MIN
       || READ_LAT > READ_LAT_MAX) begin : g_bad_param
      $error("lb_stream_ctrl: illegal DW or READ_LAT");
   end

   lb_state_t     state_q, state_d;
   logic [CW-1:0] depth_q, depth_d;
   logic [CW-1:0] occ_q, occ_d;
   logic          err_q, err_d;
   logic          acc;
   logic          pipe_empty;

   always_comb begin
      state_d  = state_q;
      depth_d  = depth_q;
      occ_d    = occ_q;
      err_d    = 1'b0;
      in_ready = 1'b0;
      mem_wen  = 1'b0;
      mem_ren  = 1'b0;
      done     = 1'b0;
      acc      = 1'b0;
      if (flush) begin
         state_d = IDLE;
         occ_d   = '0;
      end else if (clk_en) begin
         case (state_q)
            IDLE: begin
               if (cfg_start) begin
                  if (cfg_depth != '0) begin
                     depth_d = cfg_depth;
                     occ_d   = '0;
                     state_d = FILL;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            FILL: begin
               in_ready = 1'b1;
               acc      = in_valid;
               if (acc) begin
                  mem_wen = 1'b1;
                  occ_d   = occ_q + CW'(1);
                  // in_last wins over reaching depth
                  if (in_last) begin
                     state_d = DRAIN;
                  end else if (occ_q == depth_q - CW'(1)) begin
                     state_d = STEADY;
                  end
               end
            end
            STEADY: begin
               in_ready = 1'b1;
               acc      = in_valid;
               if (acc) begin
                  mem_wen = 1'b1;
                  mem_ren = 1'b1;
                  if (in_last) begin
                     state_d = DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (occ_q != '0) begin
                  mem_ren = 1'b1;
                  occ_d   = occ_q - CW'(1);
               end else if (pipe_empty) begin
                  // wait for the last read to leave the core
                  done    = 1'b1;
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
      if (reset) begin
         in_ready = 1'b0;
         mem_wen  = 1'b0;
         mem_ren  = 1'b0;
         done     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         depth_q <= '0;
         occ_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         depth_q <= depth_d;
         occ_q   <= occ_d;
         err_q   <= err_d;
      end
   end

   lb_lat_pipe #(
      .LAT (READ_LAT)
   ) u_pipe (
      .clk   (clk),
      .reset (reset),
      .en    (clk_en),
      .clr   (flush),
      .din   (mem_ren),
      .dout  (out_valid),
      .empty (pipe_empty)
   );

   assign occupancy = occ_q;
   assign busy      = (state_q != IDLE);
   assign cfg_err   = err_q;

endmodule

// File: tb/tb_lb_stream_ctrl.sv
// Directed bench for lb_stream_ctrl: vector table plus stream sequences.
// Inputs change on the falling edge and are checked 1 time unit later.
module tb_lb_stream_ctrl;

   localparam int CW  = 16;
   localparam int LAT = 2;

   logic          clk = 1'b0;
   logic          reset, clk_en, flush, cfg_start;
   logic [CW-1:0] cfg_depth;
   logic          in_valid, in_last;
   logic          in_ready, mem_wen, mem_ren, out_valid;
   logic [CW-1:0] occupancy;
   logic          busy, done, cfg_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   lb_stream_ctrl #(
      .DW       (16),
      .CW       (CW),
      .READ_LAT (LAT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .clk_en    (clk_en),
      .flush     (flush),
      .cfg_start (cfg_start),
      .cfg_depth (cfg_depth),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .mem_wen   (mem_wen),
      .mem_ren   (mem_ren),
      .out_valid (out_valid),
      .occupancy (occupancy),
      .busy      (busy),
      .done      (done),
      .cfg_err   (cfg_err)
   );

   typedef struct {
      logic          rst, fl, en, st;
      logic [CW-1:0] dep;
      logic          iv, il;
      logic          rdy, wen, ren;
      int            occ;
      logic          bsy, dn, err, ov;
   } vec_t;

   vec_t tbl[15];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic f, input logic e,
                        input logic s, input logic [CW-1:0] d,
                        input logic v, input logic l);
      @(negedge clk);
      reset     = r;
      flush     = f;
      clk_en    = e;
      cfg_start = s;
      cfg_depth = d;
      in_valid  = v;
      in_last   = l;
      #1;
   endtask

   // Feed n words into a depth-d buffer, then wait for done.
   // stall_at/flush_at: after that many accepts, stall 5 cycles / flush.
   task automatic run_stream(input string tag, input int d, input int n,
                             input int stall_at, input int flush_at,
                             input int e_wo, input int e_pair,
                             input int e_dr);
      int  acc = 0, wo = 0, pair = 0, dr = 0, ovc = 0, donec = 0;
      int  last_ren = -100, done_cyc = 0, cyc = 0, post = -1;
      bit  stalled = 0;
      logic v, l;
      drive(0, 0, 1, 1, CW'(d), 0, 0);
      while (post != 0 && cyc < 200) begin
         if (stall_at > 0 && acc == stall_at && !stalled) begin
            stalled = 1;
            for (int k = 0; k < 5; k++) begin
               drive(0, 0, 0, 0, '0, 1, 0);
               chk({tag, "_stall_strobe"}, int'(mem_wen | mem_ren), 0);
               chk({tag, "_stall_occ"}, int'(occupancy), d);
               chk({tag, "_stall_ov"}, int'(out_valid), 1);
            end
         end
         if (flush_at > 0 && acc == flush_at) begin
            drive(0, 1, 1, 0, '0, 1, 0);
            chk({tag, "_flush_done"}, int'(done), 0);
            chk({tag, "_flush_wen"}, int'(mem_wen), 0);
            drive(0, 0, 1, 0, '0, 0, 0);
            chk({tag, "_flush_busy"}, int'(busy), 0);
            chk({tag, "_flush_occ"}, int'(occupancy), 0);
            chk({tag, "_flush_ov"}, int'(out_valid), 0);
            chk({tag, "_flush_done2"}, int'(done), 0);
            return;
         end
         v = (acc < n);
         l = (acc == n - 1);
         drive(0, 0, 1, 0, '0, v, l);
         cyc++;
         if (mem_wen && !mem_ren) wo++;
         if (mem_wen && mem_ren) pair++;
         if (!mem_wen && mem_ren) dr++;
         if (mem_ren) last_ren = cyc;
         if (mem_wen) acc++;
         if (out_valid) ovc++;
         if (done) begin
            donec++;
            done_cyc = cyc;
            if (post < 0) post = 4;
         end
         if (post > 0) post--;
      end
      chk({tag, "_wen_only"}, wo, e_wo);
      chk({tag, "_wen_ren"}, pair, e_pair);
      chk({tag, "_drain_ren"}, dr, e_dr);
      chk({tag, "_out_valid"}, ovc, n);
      chk({tag, "_done_cnt"}, donec, 1);
      chk({tag, "_done_lat"}, done_cyc - last_ren, 1 + LAT);
      chk({tag, "_busy_end"}, int'(busy), 0);
   endtask

   initial begin
      //          rst fl en st dep iv il  rdy wen ren occ bsy dn err ov
      tbl[0]  = '{0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0};
      tbl[1]  = '{0, 0, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0};
      tbl[2]  = '{0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0};
      tbl[3]  = '{0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0};
      tbl[4]  = '{0, 0, 1, 1, 3, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0};
      tbl[5]  = '{0, 0, 1, 0, 0, 1, 0,  1, 1, 0, 0, 1, 0, 0, 0};
      tbl[6]  = '{0, 0, 1, 0, 0, 1, 0,  1, 1, 0, 1, 1, 0, 0, 0};
      tbl[7]  = '{0, 0, 1, 0, 0, 1, 0,  1, 1, 0, 2, 1, 0, 0, 0};
      tbl[8]  = '{0, 0, 1, 0, 0, 1, 0,  1, 1, 1, 3, 1, 0, 0, 0};
      tbl[9]  = '{0, 0, 1, 0, 0, 0, 0,  1, 0, 0, 3, 1, 0, 0, 0};
      tbl[10] = '{0, 0, 1, 0, 0, 1, 1,  1, 1, 1, 3, 1, 0, 0, 1};
      tbl[11] = '{1, 0, 1, 0, 0, 0, 0,  0, 0, 0, 3, 1, 0, 0, 0};
      tbl[12] = '{0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0};
      tbl[13] = '{0, 0, 0, 1, 5, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0};
      tbl[14] = '{0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0};

      drive(1, 0, 1, 0, '0, 0, 0);
      drive(1, 0, 1, 0, '0, 0, 0);

      for (int i = 0; i < 15; i++) begin
         drive(tbl[i].rst, tbl[i].fl, tbl[i].en, tbl[i].st,
               tbl[i].dep, tbl[i].iv, tbl[i].il);
         chk($sformatf("v%0d_in_ready", i), int'(in_ready), int'(tbl[i].rdy));
         chk($sformatf("v%0d_mem_wen", i), int'(mem_wen), int'(tbl[i].wen));
         chk($sformatf("v%0d_mem_ren", i), int'(mem_ren), int'(tbl[i].ren));
         chk($sformatf("v%0d_occ", i), int'(occupancy), tbl[i].occ);
         chk($sformatf("v%0d_busy", i), int'(busy), int'(tbl[i].bsy));
         chk($sformatf("v%0d_done", i), int'(done), int'(tbl[i].dn));
         chk($sformatf("v%0d_cfg_err", i), int'(cfg_err), int'(tbl[i].err));
         chk($sformatf("v%0d_out_valid", i), int'(out_valid), int'(tbl[i].ov));
      end

      run_stream("d4n10", 4, 10, 0, 0, 4, 6, 4);
      run_stream("d8n3", 8, 3, 0, 0, 3, 0, 3);
      run_stream("d1n3", 1, 3, 0, 0, 1, 2, 1);
      run_stream("stall", 4, 10, 6, 0, 4, 6, 4);
      run_stream("flush", 4, 10, 0, 6, 0, 0, 0);
      run_stream("refill", 2, 3, 0, 0, 2, 1, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
